rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource (bus, port, or memory bank) between up to four clients. Priority rotates so that no requester starves. The winning index is registered, and the one-hot grant vector is produced by the team's existing 2-to-4 decoder, with the decoder's enable driven by grant-valid. The block sits between client request lines and the resource's select or enable inputs.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may keep the grant while others wait. Legal range ≥2. Only used when the timeout feature is compiled in.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: request lines; bit i = requester i. Level-sensitive; a requester holds `req[i]` high for as long as it wants the resource.
- `gnt`  out  4: one-hot grant. All zero when idle. Decoded from `gnt_id` with enable = `gnt_valid`.
- `gnt_id`  out  2: index of the current grant holder. Holds its last value when idle.
- `gnt_valid`  out  1: high while a grant is active.

## Operation
- **State machine** (2 states):
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
- **Rotating pointer** `ptr[1:0]`: search for a winner starts at `ptr` and proceeds `ptr+1, ptr+2, ptr+3` (mod 4). The first set `req` bit wins.
- **Pointer update:** on every new grant, `ptr <= winner+1` (mod 4). Wrap-around: winner 3 sets `ptr` to 0.
- **IDLE transitions:**
  - Any `req` set: go to GRANT with the search winner.
  - `req == 0`: stay in IDLE.
- **GRANT, holder keeps `req[gnt_id]` high:** hold the grant. Other requests do not preempt, except via timeout.
- **GRANT, holder drops `req[gnt_id]`:**
  - Others pending: re-arbitrate the same cycle and grant the new winner on the next edge. Back-to-back grants, no idle cycle.
  - None pending: return to IDLE.
- **Simultaneous requests:** resolved purely by pointer order. A new request arriving in the same cycle as a release is included in the search.
- **`hold_cnt`:**
  - Width `$clog2(HOLD_MAX)`.
  - Cleared on every new grant; increments each GRANT cycle.
  - Saturates at `HOLD_MAX-1`; never wraps.
- **Reset:**
  - Outputs: `gnt=4'b0000`, `gnt_id=2'b00`, `gnt_valid=0`.
  - Internal: `ptr=0`, `hold_cnt=0`, state IDLE.
  - Reset asserted mid-grant: `gnt` clears at that edge regardless of `req`.

## Timing
- **Grant latency:** `req` sampled at edge N in IDLE → `gnt`/`gnt_valid` high after edge N+1. One cycle, registered.
- **Release:** holder drops `req` before edge N → after edge N, `gnt` shows the next winner, or 0 if none pending.
- **Outputs:** `gnt_id` and `gnt_valid` are flops. `gnt` is combinational from those flops only. No `req`-to-`gnt` combinational path.
- **Minimum grant length:** 1 cycle.

## Configuration
- **`RR_ARB_TIMEOUT_EN` defined:**
  - When `hold_cnt == HOLD_MAX-1` and any other `req` bit is set, the grant is forcibly revoked.
  - The next winner, searched from `ptr` and excluding the current holder, is granted on the next edge.
  - A holder with no competitors keeps the grant indefinitely.
- **`RR_ARB_TIMEOUT_EN` not defined:**
  - `hold_cnt` logic is removed.
  - The grant persists until the holder drops `req`. `HOLD_MAX` is ignored.

## Structure
- **Shared package `rr_arb_pkg`:**
  - `NUM_REQ=4`.
  - State encoding constants `ST_IDLE=1'b0`, `ST_GRANT=1'b1`.
  - Default `HOLD_MAX` constant.
- **Sub-module:** one instance of the existing `decoder2to4`, with `in=gnt_id`, `en=gnt_valid`, `out=gnt`.
- **Search logic:** pointer-relative priority search stays inline in `rr_arbiter4`.

## Test plan
- **Reset then single request:**
  - Stimulus: `rst` high 2 cycles; then `req=4'b0100`.
  - Required response: after one edge, `gnt=4'b0100`, `gnt_id=2`, `gnt_valid=1`; `ptr` becomes 3.
- **Fairness, all requesting:**
  - Stimulus: from reset, `req=4'b1111`; each holder releases after 1 cycle and re-requests.
  - Required response: `gnt_id` sequence 0,1,2,3,0; `gnt` never has more than one bit set.
- **Back-to-back handoff:**
  - Stimulus: holder 1 drops `req` while `req[3]` is set.
  - Required response: the next cycle shows `gnt=4'b1000`, with no zero cycle in between.
- **Idle return:**
  - Stimulus: sole holder 2 drops `req`.
  - Required response: `gnt=4'b0000`, `gnt_valid=0`, `gnt_id` stays 2.
- **Timeout (`RR_ARB_TIMEOUT_EN`, `HOLD_MAX=4`):**
  - Stimulus: requester 0 holds continuously; `req[2]` asserts at grant cycle 1.
  - Required response: `gnt` switches to `4'b0100` after the 4th grant cycle.
  - Same stimulus without the macro: requester 0 keeps the grant.
- **Reset mid-grant:**
  - Stimulus: `rst` asserted while `gnt=4'b0010` and `req=4'b1111`.
  - Required response: `gnt=0` after that edge. After release, the first grant goes to 0, since `ptr` resets to 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared constants and types for the four-requester round-robin arbiter.
//   NUM_REQ          : number of requesters served by the arbiter
//   HOLD_MAX_DEFAULT : default limit on consecutive grant cycles while others
//                      wait (only meaningful with RR_ARB_TIMEOUT_EN defined)
//   state_t          : arbiter FSM encoding (ST_IDLE = 0, ST_GRANT = 1)
// ---------------------------------------------------------------------------
package rr_arb_pkg;

  localparam int NUM_REQ          = 4;
  localparam int HOLD_MAX_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/decoder2to4.sv
// ---------------------------------------------------------------------------
// decoder2to4
// 2-to-4 one-hot decoder with enable.
//   in  : 2-bit index to decode
//   en  : when low the output is all zero
//   out : one-hot decode of in, gated by en
// ---------------------------------------------------------------------------
module decoder2to4 (
  input  logic [1:0] in,
  input  logic       en,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (en) begin
      out = 4'b0001 << in;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter. A rotating pointer sets the start of
// the priority search; the winning index is registered and decoded to a
// one-hot grant. The current holder keeps the grant for as long as it holds
// its request; on release the next winner is granted on the following edge
// with no idle cycle in between.
//
// Optional feature (macro RR_ARB_TIMEOUT_EN): a holder that has owned the
// resource for HOLD_MAX consecutive cycles while another requester waits is
// forcibly revoked and the next winner (holder excluded) is granted.
//
// Handshake: req[i] is a level request; gnt[i] is the acknowledgement. A
// grant is presented one edge after the request is sampled and is held until
// the holder deasserts req[i] (or a timeout revokes it). There is no
// combinational path from req to gnt.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   req[3:0]    : request lines, bit i = requester i
//   gnt[3:0]    : one-hot grant, all zero when idle
//   gnt_id[1:0] : index of current/last grant holder (held while idle)
//   gnt_valid   : high while a grant is active
//   o_dbg_state : FSM state (0 = idle, 1 = grant) for observation
// ---------------------------------------------------------------------------
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       o_dbg_state
);

  if (HOLD_MAX < 2) begin : g_bad_hold_max
    $error("rr_arbiter4: HOLD_MAX must be at least 2");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_gnt_id;
  logic [1:0] w_gnt_id_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] w_holder_oh;
  logic [3:0] w_cand;
  logic       w_found;
  logic [1:0] w_win;
  logic       w_new_grant;
  logic       w_timeout;

  // While granting, the holder is never a candidate: either it released, or
  // it is being revoked and must not win its own re-arbitration.
  always_comb begin
    w_holder_oh = 4'b0001 << r_gnt_id;
    w_cand      = (r_state == ST_GRANT) ? (req & ~w_holder_oh) : req;
  end

  // Pointer-relative search. Scanned from the farthest offset down so the
  // nearest set bit (starting at r_ptr) is the last assignment and wins.
  always_comb begin
    logic [1:0] w_idx;
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int              HCW       = $clog2(HOLD_MAX);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

  logic [HCW-1:0] r_hold_cnt;
  logic [HCW-1:0] w_hold_nxt;

  always_comb begin
    w_timeout = (r_hold_cnt == HOLD_LAST) && (|w_cand);
  end

  // Cleared on each new grant, counts grant cycles, saturates at HOLD_LAST.
  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if (w_new_grant) begin
      w_hold_nxt = '0;
    end else if ((r_state == ST_GRANT) && (r_hold_cnt != HOLD_LAST)) begin
      w_hold_nxt = r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
    end
  end
`else
  always_comb begin
    w_timeout = 1'b0;
  end
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_id_nxt = r_gnt_id;
    w_ptr_nxt    = r_ptr;
    w_new_grant  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_new_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req[r_gnt_id] || w_timeout) begin
          if (w_found) begin
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_new_grant) begin
      w_gnt_id_nxt = w_win;
      w_ptr_nxt    = w_win + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt_id <= 2'd0;
      r_ptr    <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  always_comb begin
    gnt_id      = r_gnt_id;
    gnt_valid   = (r_state == ST_GRANT);
    o_dbg_state = r_state;
  end

  decoder2to4 u_dec (
    .in  (r_gnt_id),
    .en  (gnt_valid),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {gnt_valid, gnt_id[1:0], gnt[3:0]}
  logic [6:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  function automatic logic [6:0] e(input logic v, input logic [1:0] id, input logic [3:0] g);
    return {v, id, g};
  endfunction

  // Driver: one call = one clock cycle; the expectation describes the
  // outputs seen just after the next rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [6:0] exp, input string nm);
    @(negedge clk);
    rst = r;
    req = rq;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle; sample #1 after the edge.
  initial begin
    logic [6:0] exp;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        checks++;
        if ($countones(gnt) > 1) begin
          errors++;
          $display("FAIL onehot: gnt=%b has more than one bit set, required at most one", gnt);
        end
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          nm  = name_q.pop_front();
          checks++;
          if ({gnt_valid, gnt_id, gnt} !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%0b id=%0d gnt=%b, required valid=%0b id=%0d gnt=%b",
                     nm, gnt_valid, gnt_id, gnt, exp[6], exp[5:4], exp[3:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req = 4'b0000;
    mon_en = 1'b1;

    // Reset, then a single request from requester 2 (ptr becomes 3)
    step(1'b1, 4'b0000, e(1'b0, 2'd0, 4'b0000), "reset_0");
    step(1'b1, 4'b0000, e(1'b0, 2'd0, 4'b0000), "reset_1");
    step(1'b0, 4'b0100, e(1'b1, 2'd2, 4'b0100), "single_req2");
    // Sole holder drops: idle, gnt_id stays 2
    step(1'b0, 4'b0000, e(1'b0, 2'd2, 4'b0000), "idle_return");

    // Fairness from reset, each holder releases after one cycle
    step(1'b1, 4'b1111, e(1'b0, 2'd0, 4'b0000), "fair_reset");
    step(1'b0, 4'b1111, e(1'b1, 2'd0, 4'b0001), "fair_0");
    step(1'b0, 4'b1110, e(1'b1, 2'd1, 4'b0010), "fair_1");
    step(1'b0, 4'b1101, e(1'b1, 2'd2, 4'b0100), "fair_2");
    step(1'b0, 4'b1011, e(1'b1, 2'd3, 4'b1000), "fair_3");
    step(1'b0, 4'b0111, e(1'b1, 2'd0, 4'b0001), "fair_wrap_0");

    // Back-to-back: holder 0 drops, 1 wins (ptr=1); then 1 drops while 3 waits
    step(1'b0, 4'b1010, e(1'b1, 2'd1, 4'b0010), "b2b_hold1");
    step(1'b0, 4'b1000, e(1'b1, 2'd3, 4'b1000), "b2b_handoff3");
    step(1'b0, 4'b1000, e(1'b1, 2'd3, 4'b1000), "hold3");
    step(1'b0, 4'b0000, e(1'b0, 2'd3, 4'b0000), "idle_after3");

    // Timeout scenario (HOLD_MAX=4): 0 holds, 2 waits from grant cycle 1
    step(1'b0, 4'b0001, e(1'b1, 2'd0, 4'b0001), "to_grant0");
    step(1'b0, 4'b0101, e(1'b1, 2'd0, 4'b0001), "to_cycle2");
    step(1'b0, 4'b0101, e(1'b1, 2'd0, 4'b0001), "to_cycle3");
    step(1'b0, 4'b0101, e(1'b1, 2'd0, 4'b0001), "to_cycle4");
    step(1'b0, 4'b0101, TO_EN ? e(1'b1, 2'd2, 4'b0100) : e(1'b1, 2'd0, 4'b0001), "to_switch");
    step(1'b0, 4'b0101, TO_EN ? e(1'b1, 2'd2, 4'b0100) : e(1'b1, 2'd0, 4'b0001), "to_after");
    step(1'b0, 4'b0000, TO_EN ? e(1'b0, 2'd2, 4'b0000) : e(1'b0, 2'd0, 4'b0000), "to_idle");

    // Reset mid-grant while holder is 1 and everyone requests
    step(1'b0, 4'b0010, e(1'b1, 2'd1, 4'b0010), "pre_rst_grant1");
    step(1'b1, 4'b1111, e(1'b0, 2'd0, 4'b0000), "rst_mid_grant");
    step(1'b0, 4'b1111, e(1'b1, 2'd0, 4'b0001), "post_rst_ptr0");
    step(1'b0, 4'b0000, e(1'b0, 2'd0, 4'b0000), "final_idle");

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
